// File: rtl/writeback_unit_pkg.sv
// Shared types for the writeback slice: register ids, the register-file
// write port bundle, load funct3 encodings and the load queue entry.
package writeback_unit_pkg;

    localparam int XLEN = 32;

    typedef logic [4:0] rv_reg_t;

    typedef struct packed {
        logic            enable;
        rv_reg_t         which_register;
        logic [XLEN-1:0] value;
    } reg_write_control_t;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    typedef struct packed {
        rv_reg_t    rd;
        logic [2:0] funct3;
        logic [1:0] offset;
        logic       writes_rd;
    } load_q_entry_t;

endpackage

// File: rtl/writeback_unit_load_extend.sv
// Combinational load data select/extend: picks byte or halfword from an
// aligned word by offset and sign/zero-extends per funct3.
// Ports: funct3, offset, data in; value out.
module load_extend
    import writeback_unit_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = data[{offset, 3'b000} +: 8];
        // offset[0] is ignored for halfwords
        half_sel = offset[1] ? data[31:16] : data[15:0];
        case (funct3)
            FUNCT3_LB:  value = {{24{byte_sel[7]}}, byte_sel};
            FUNCT3_LH:  value = {{16{half_sel[15]}}, half_sel};
            FUNCT3_LBU: value = {24'b0, byte_sel};
            FUNCT3_LHU: value = {16'b0, half_sel};
            default:    value = data;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Serialises execute results and in-order load responses onto the single
// register-file write port; tracks outstanding loads and flags RAW hazards.
// Ports: exec_* retire handshake, mem_resp_* load data, write_control out,
// query_rs1/2 + hazard for decode, load_q_full, sticky resp_error.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int LOAD_Q_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               exec_valid,
    output logic               exec_ready,
    input  rv_reg_t            exec_rd,
    input  logic               exec_writes_rd,
    input  logic               exec_is_load,
    input  logic [2:0]         exec_load_funct3,
    input  logic [1:0]         exec_load_offset,
    input  logic [XLEN-1:0]    exec_value,
    input  logic               mem_resp_valid,
    input  logic [XLEN-1:0]    mem_resp_data,
    output reg_write_control_t write_control,
    input  rv_reg_t            query_rs1,
    input  rv_reg_t            query_rs2,
    output logic               hazard,
    output logic               load_q_full,
    output logic               resp_error
);

    localparam int PTR_W = $clog2(LOAD_Q_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    load_q_entry_t     q_mem [LOAD_Q_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              skid_valid;
    rv_reg_t           skid_rd;
    logic [XLEN-1:0]   skid_value;

    logic              accept;
    logic              enq;
    logic              pop;
    logic              exec_write;
    logic              skid_set;
    logic              skid_clear;
    load_q_entry_t     head_entry;
    logic [XLEN-1:0]   load_value;
    reg_write_control_t wc_next;

    logic              hit1;
    logic              hit2;
    logic [PTR_W-1:0]  age;

    assign load_q_full = (count == CNT_W'(LOAD_Q_DEPTH));
    // Full blocks loads even when a pop lands in the same cycle
    assign exec_ready  = !skid_valid && !(exec_is_load && load_q_full);
    assign accept      = exec_valid && exec_ready;
    assign enq         = accept && exec_is_load;
    assign exec_write  = accept && !exec_is_load && exec_writes_rd
                         && (exec_rd != '0);
    assign pop         = mem_resp_valid && (count != '0);
    assign head_entry  = q_mem[head];

    load_extend u_load_extend (
        .funct3 (head_entry.funct3),
        .offset (head_entry.offset),
        .data   (mem_resp_data),
        .value  (load_value)
    );

    always_comb begin
        wc_next = '0;
        priority case (1'b1)
            pop: begin
                if (head_entry.writes_rd && head_entry.rd != '0)
                    wc_next = '{1'b1, head_entry.rd, load_value};
            end
            skid_valid: wc_next = '{1'b1, skid_rd, skid_value};
            exec_write: wc_next = '{1'b1, exec_rd, exec_value};
            default: ;
        endcase
    end

    // skid_valid and exec_write never coexist: exec_ready is low then
    assign skid_set   = exec_write && pop;
    assign skid_clear = skid_valid && !pop;

    always_ff @(posedge clock) begin
        if (enq)
            q_mem[tail] <= '{exec_rd, exec_load_funct3,
                             exec_load_offset, exec_writes_rd};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            skid_valid    <= 1'b0;
            skid_rd       <= '0;
            skid_value    <= '0;
            write_control <= '0;
            resp_error    <= 1'b0;
        end else begin
            write_control <= wc_next;
            if (enq)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (skid_set) begin
                skid_valid <= 1'b1;
                skid_rd    <= exec_rd;
                skid_value <= exec_value;
            end else if (skid_clear) begin
                skid_valid <= 1'b0;
            end
            if (mem_resp_valid && count == '0)
                resp_error <= 1'b1;
        end
    end

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        age  = '0;
        for (int i = 0; i < LOAD_Q_DEPTH; i++) begin
            // slot i is live when its distance from head is below count
            age = PTR_W'(i) - head;
            if ({1'b0, age} < count && q_mem[i].writes_rd) begin
                if (q_mem[i].rd == query_rs1) hit1 = 1'b1;
                if (q_mem[i].rd == query_rs2) hit2 = 1'b1;
            end
        end
        if (skid_valid && skid_rd == query_rs1) hit1 = 1'b1;
        if (skid_valid && skid_rd == query_rs2) hit2 = 1'b1;
        if (write_control.enable) begin
            if (write_control.which_register == query_rs1) hit1 = 1'b1;
            if (write_control.which_register == query_rs2) hit2 = 1'b1;
        end
    end

    assign hazard = (query_rs1 != '0 && hit1) || (query_rs2 != '0 && hit2);

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: write-port scoreboard, load
// extension vector table and hand sequences for skid/full/hazard/reset.
module tb_writeback_unit;
    import writeback_unit_pkg::*;

    logic               clock = 1'b0;
    logic               reset;
    logic               exec_valid;
    logic               exec_ready;
    rv_reg_t            exec_rd;
    logic               exec_writes_rd;
    logic               exec_is_load;
    logic [2:0]         exec_load_funct3;
    logic [1:0]         exec_load_offset;
    logic [XLEN-1:0]    exec_value;
    logic               mem_resp_valid;
    logic [XLEN-1:0]    mem_resp_data;
    reg_write_control_t write_control;
    rv_reg_t            query_rs1;
    rv_reg_t            query_rs2;
    logic               hazard;
    logic               load_q_full;
    logic               resp_error;

    always #5 clock = ~clock;

    writeback_unit #(.LOAD_Q_DEPTH(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .exec_valid       (exec_valid),
        .exec_ready       (exec_ready),
        .exec_rd          (exec_rd),
        .exec_writes_rd   (exec_writes_rd),
        .exec_is_load     (exec_is_load),
        .exec_load_funct3 (exec_load_funct3),
        .exec_load_offset (exec_load_offset),
        .exec_value       (exec_value),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data),
        .write_control    (write_control),
        .query_rs1        (query_rs1),
        .query_rs2        (query_rs2),
        .hazard           (hazard),
        .load_q_full      (load_q_full),
        .resp_error       (resp_error)
    );

    typedef struct {
        rv_reg_t    rd;
        logic [2:0] f3;
        logic [1:0] off;
    } ld_t;

    typedef struct {
        rv_reg_t     rd;
        logic [31:0] value;
    } wr_t;

    typedef struct {
        rv_reg_t     rd;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    ld_t mq[$];
    wr_t exp_q[$];
    wr_t mon_e;
    int  total = 0;
    int  bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ext_model(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [31:0] d);
        logic [31:0] sh;
        logic [15:0] h;
        sh = d >> (32'(off) * 8);
        h  = off[1] ? d[31:16] : d[15:0];
        case (f3)
            FUNCT3_LB:  return {{24{sh[7]}}, sh[7:0]};
            FUNCT3_LH:  return {{16{h[15]}}, h};
            FUNCT3_LBU: return {24'b0, sh[7:0]};
            FUNCT3_LHU: return {16'b0, h};
            default:    return d;
        endcase
    endfunction

    // Write-port monitor: every enable pulse must match the next expected
    always @(negedge clock) begin
        if (!reset) begin
            if (write_control.enable) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write actual=rd%0d/%0h required=none",
                             write_control.which_register, write_control.value);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wb_write",
                        64'({write_control.which_register, write_control.value}),
                        64'({mon_e.rd, mon_e.value}));
                end
            end else begin
                chk("idle_zero",
                    64'({write_control.which_register, write_control.value}),
                    64'(0));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        exec_valid       = 1'b0;
        exec_rd          = '0;
        exec_writes_rd   = 1'b0;
        exec_is_load     = 1'b0;
        exec_load_funct3 = '0;
        exec_load_offset = '0;
        exec_value       = '0;
        mem_resp_valid   = 1'b0;
        mem_resp_data    = '0;
    endtask

    task automatic issue(input rv_reg_t rd, input logic wr, input logic ld,
                         input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] val);
        int n = 0;
        exec_valid       = 1'b1;
        exec_rd          = rd;
        exec_writes_rd   = wr;
        exec_is_load     = ld;
        exec_load_funct3 = f3;
        exec_load_offset = off;
        exec_value       = val;
        #1;
        while (!exec_ready && n < 40) begin
            step();
            n++;
        end
        if (!exec_ready) begin
            total++;
            bad++;
            $display("FAIL issue_timeout actual=ready0 required=ready1");
            exec_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        exec_valid = 1'b0;
        if (ld)
            mq.push_back('{rd, f3, off});
        else if (wr && rd != 0)
            exp_q.push_back('{rd, val});
    endtask

    task automatic respond(input logic [31:0] data, input logic use_ovr,
                           input logic [31:0] ovr);
        ld_t e;
        mem_resp_valid = 1'b1;
        mem_resp_data  = data;
        if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.rd != 0)
                exp_q.push_back('{e.rd, use_ovr ? ovr
                                  : ext_model(e.f3, e.off, data)});
        end
        step();
        mem_resp_valid = 1'b0;
    endtask

    vec_t        tab[12];
    logic [2:0]  f3s[5];

    initial begin
        tab[0]  = '{7,  FUNCT3_LB,  2, 32'h0080FF00, 32'hFFFFFF80};
        tab[1]  = '{7,  FUNCT3_LHU, 2, 32'h0080FF00, 32'h00000080};
        tab[2]  = '{8,  FUNCT3_LBU, 1, 32'h0080FF00, 32'h000000FF};
        tab[3]  = '{8,  FUNCT3_LB,  1, 32'h0080FF00, 32'hFFFFFFFF};
        tab[4]  = '{11, FUNCT3_LH,  0, 32'h0080FF00, 32'hFFFFFF00};
        tab[5]  = '{11, FUNCT3_LH,  1, 32'h0080FF00, 32'hFFFFFF00};
        tab[6]  = '{12, FUNCT3_LW,  0, 32'h12345678, 32'h12345678};
        tab[7]  = '{12, FUNCT3_LB,  3, 32'h12345678, 32'h00000012};
        tab[8]  = '{13, FUNCT3_LH,  3, 32'h8765ABCD, 32'hFFFF8765};
        tab[9]  = '{13, FUNCT3_LBU, 0, 32'h8765ABCD, 32'h000000CD};
        tab[10] = '{31, FUNCT3_LHU, 0, 32'h8765ABCD, 32'h0000ABCD};
        tab[11] = '{31, FUNCT3_LB,  3, 32'h7F000000, 32'h0000007F};
        f3s[0] = FUNCT3_LB;
        f3s[1] = FUNCT3_LH;
        f3s[2] = FUNCT3_LW;
        f3s[3] = FUNCT3_LBU;
        f3s[4] = FUNCT3_LHU;

        clear_inputs();
        query_rs1 = '0;
        query_rs2 = '0;
        reset     = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("rst_ready", 64'(exec_ready), 64'(1));
        chk("rst_enable", 64'(write_control.enable), 64'(0));
        chk("rst_resp_error", 64'(resp_error), 64'(0));
        chk("rst_full", 64'(load_q_full), 64'(0));
        chk("rst_hazard", 64'(hazard), 64'(0));

        // ALU writer: visible one cycle after acceptance
        issue(5, 1'b1, 1'b0, 3'b0, 2'b0, 32'h1234);
        chk("add_write",
            64'({write_control.enable, write_control.which_register,
                 write_control.value}),
            64'({1'b1, 5'd5, 32'h1234}));
        chk("add_ready", 64'(exec_ready), 64'(1));
        step();

        // Non-writer beat produces nothing
        issue(6, 1'b0, 1'b0, 3'b0, 2'b0, 32'hDEAD);
        step();

        // Load extension table
        for (int i = 0; i < 12; i++) begin
            issue(tab[i].rd, 1'b1, 1'b1, tab[i].f3, tab[i].off, 32'h0);
            respond(tab[i].data, 1'b1, tab[i].exp);
            step();
        end

        // Response and exec beat collide: exec value parks in the skid
        issue(3, 1'b1, 1'b1, FUNCT3_LW, 2'b0, 32'h0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hAAAA5555;
        exec_valid     = 1'b1;
        exec_rd        = 4;
        exec_writes_rd = 1'b1;
        exec_is_load   = 1'b0;
        exec_value     = 32'h44;
        void'(mq.pop_front());
        exp_q.push_back('{5'd3, 32'hAAAA5555});
        exp_q.push_back('{5'd4, 32'h44});
        #1;
        chk("collide_ready", 64'(exec_ready), 64'(1));
        step();
        clear_inputs();
        #1;
        chk("skid_first",
            64'({write_control.enable, write_control.which_register}),
            64'({1'b1, 5'd3}));
        chk("skid_blocks_ready", 64'(exec_ready), 64'(0));
        step();
        chk("skid_second",
            64'({write_control.enable, write_control.which_register,
                 write_control.value}),
            64'({1'b1, 5'd4, 32'h44}));
        chk("skid_ready_back", 64'(exec_ready), 64'(1));
        step();

        // Fill the queue; fifth load waits for a free slot
        for (int r = 1; r <= 4; r++)
            issue(r[4:0], 1'b1, 1'b1, FUNCT3_LW, 2'b0, 32'h0);
        chk("full_at_4", 64'(load_q_full), 64'(1));
        exec_valid       = 1'b1;
        exec_rd          = 5;
        exec_writes_rd   = 1'b1;
        exec_is_load     = 1'b1;
        exec_load_funct3 = FUNCT3_LW;
        exec_load_offset = 2'b0;
        #1;
        chk("full_blocks_load", 64'(exec_ready), 64'(0));
        respond(32'h11, 1'b0, 32'h0);
        chk("pop_frees_slot", 64'(load_q_full), 64'(0));
        chk("ready_after_pop", 64'(exec_ready), 64'(1));
        step();
        exec_valid = 1'b0;
        mq.push_back('{5'd5, FUNCT3_LW, 2'b0});
        chk("full_again", 64'(load_q_full), 64'(1));
        while (mq.size() > 0)
            respond($urandom, 1'b0, 32'h0);
        step();

        // Ten loads across pointer wrap, mixed widths
        for (int i = 0; i < 10; i++) begin
            issue(5'(10 + i), 1'b1, 1'b1, f3s[$urandom_range(0, 4)],
                  2'($urandom_range(0, 3)), 32'h0);
            if (mq.size() >= 3)
                respond($urandom, 1'b0, 32'h0);
        end
        while (mq.size() > 0)
            respond($urandom, 1'b0, 32'h0);
        step();

        // Hazard lifetime of a pending load
        issue(9, 1'b1, 1'b1, FUNCT3_LW, 2'b0, 32'h0);
        query_rs1 = 9;
        #1;
        chk("hz_pending", 64'(hazard), 64'(1));
        step();
        chk("hz_still", 64'(hazard), 64'(1));
        respond(32'h99, 1'b0, 32'h0);
        chk("hz_on_write", 64'(hazard), 64'(1));
        step();
        chk("hz_cleared", 64'(hazard), 64'(0));

        // x0 load: no hazard, no write, but it holds a slot
        issue(0, 1'b1, 1'b1, FUNCT3_LW, 2'b0, 32'h0);
        query_rs2 = 0;
        #1;
        chk("hz_x0", 64'(hazard), 64'(0));
        for (int r = 20; r <= 22; r++)
            issue(r[4:0], 1'b1, 1'b1, FUNCT3_LW, 2'b0, 32'h0);
        chk("x0_full", 64'(load_q_full), 64'(1));
        respond(32'h5A5A5A5A, 1'b0, 32'h0);
        chk("x0_popped", 64'(load_q_full), 64'(0));
        while (mq.size() > 0)
            respond($urandom, 1'b0, 32'h0);
        step();

        // Orphan response
        chk("err_before", 64'(resp_error), 64'(0));
        respond(32'h1, 1'b0, 32'h0);
        chk("err_set", 64'(resp_error), 64'(1));
        step();
        chk("err_sticky", 64'(resp_error), 64'(1));

        // Reset with two loads in flight
        issue(9, 1'b1, 1'b1, FUNCT3_LW, 2'b0, 32'h0);
        issue(10, 1'b1, 1'b1, FUNCT3_LW, 2'b0, 32'h0);
        query_rs1 = 9;
        #1;
        chk("hz_before_rst", 64'(hazard), 64'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        mq.delete();
        #1;
        chk("mid_rst_hazard", 64'(hazard), 64'(0));
        chk("mid_rst_err", 64'(resp_error), 64'(0));
        chk("mid_rst_full", 64'(load_q_full), 64'(0));
        chk("mid_rst_ready", 64'(exec_ready), 64'(1));
        for (int r = 1; r <= 3; r++)
            issue(r[4:0], 1'b1, 1'b1, FUNCT3_LW, 2'b0, 32'h0);
        chk("rst_count_3", 64'(load_q_full), 64'(0));
        issue(4, 1'b1, 1'b1, FUNCT3_LW, 2'b0, 32'h0);
        chk("rst_count_4", 64'(load_q_full), 64'(1));
        while (mq.size() > 0)
            respond($urandom, 1'b0, 32'h0);

        repeat (3) step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
